// File: rtl/fifo_burst_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_burst_ctrl
//   Sequences one capture burst through the sample FIFO.
//   1. Gates a fixed number of source samples into the FIFO push port.
//   2. Holds readout until the FIFO reaches a prefill level.
//   3. Drains exactly that many samples to a valid/ready stream and marks the
//      final beat.
//   It also owns the FIFO clear, overflow supervision and the completion pulse.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   start, abort                   one-cycle arm / cancel pulses
//   burst_len_cfg                  samples per burst (latched on start)
//   src_data, src_vld              sample source (no backpressure)
//   fifo_in_data, fifo_in_vld      FIFO push port
//   fifo_out_data, fifo_out_vld    FIFO head / non-empty
//   fifo_out_rdy                   FIFO pop strobe
//   fifo_size, fifo_overflow       FIFO occupancy and overflow event
//   fifo_clr                       FIFO synchronous clear
//   m_data, m_vld, m_last, m_rdy   output stream
//   busy, done, err                status (err is sticky until abort)
//   push_cnt, pop_cnt              progress of the current burst
// -----------------------------------------------------------------------------
module fifo_burst_ctrl #(
  parameter int  DATA_WIDTH = 32,
  parameter int  FIFO_SIZE  = 1024,
  parameter int  MAX_BURST  = 4096,
  parameter int  PREFILL    = 16,
  localparam int LEN_W      = $clog2(MAX_BURST + 1),
  localparam int SZ_W       = $clog2(FIFO_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      burst_len_cfg,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_vld,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  output logic                  fifo_in_vld,
  input  logic [DATA_WIDTH-1:0] fifo_out_data,
  input  logic                  fifo_out_vld,
  output logic                  fifo_out_rdy,
  input  logic [SZ_W-1:0]       fifo_size,
  input  logic                  fifo_overflow,
  output logic                  fifo_clr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_vld,
  output logic                  m_last,
  input  logic                  m_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_W-1:0]      push_cnt,
  output logic [LEN_W-1:0]      pop_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [SZ_W-1:0]  FULL_LVL    = SZ_W'(FIFO_SIZE);
  localparam logic [SZ_W-1:0]  PREFILL_LVL = SZ_W'(PREFILL);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FILL, S_STREAM, S_FLUSH, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_push_cnt;
  logic [LEN_W-1:0] r_pop_cnt;
  logic             r_err;
  logic             r_done;
  logic             r_fifo_clr;

  logic             w_busy;
  logic             w_push_en;
  logic             w_pop_en;
  logic             w_push;
  logic             w_push_acc;
  logic             w_pop;
  logic             w_last;
  logic             w_ovf;
  logic             w_start_ok;
  logic [LEN_W-1:0] w_len_clamped;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; overflow outranks normal sequencing, abort outranks all
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (w_len_clamped == '0) ? S_DONE : S_CLR;
      S_CLR:    w_next = S_FILL;
      S_FILL: begin
        if (r_push_cnt == r_len)            w_next = S_FLUSH;
        else if (fifo_size >= PREFILL_LVL)  w_next = S_STREAM;
      end
      S_STREAM: if (r_push_cnt == r_len) w_next = S_FLUSH;
      // The registered check covers a final pop that landed while still in STREAM.
      S_FLUSH:  if ((r_pop_cnt == r_len) || (w_pop && w_last)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
    if (w_ovf) w_next = S_ERR;
    if (abort) w_next = S_IDLE;
  end

  // Output decode
  always_comb begin
    w_busy    = 1'b0;
    w_push_en = 1'b0;
    w_pop_en  = 1'b0;
    case (r_state)
      S_CLR:    w_busy = 1'b1;
      S_FILL: begin
        w_busy    = 1'b1;
        w_push_en = (r_push_cnt < r_len);
      end
      S_STREAM: begin
        w_busy    = 1'b1;
        w_push_en = (r_push_cnt < r_len);
        w_pop_en  = (r_pop_cnt < r_len);
      end
      S_FLUSH: begin
        w_busy    = 1'b1;
        w_pop_en  = (r_pop_cnt < r_len);
      end
      default: ;
    endcase
  end

  assign w_len_clamped = (burst_len_cfg > MAX_LEN) ? MAX_LEN : burst_len_cfg;
  assign w_start_ok    = (r_state == S_IDLE) && start && !abort;

  // Push path: samples arriving outside the push window are simply dropped.
  assign w_push     = src_vld && w_push_en;
  // A push into a full FIFO is lost, so it is not counted.
  assign w_push_acc = w_push && (fifo_size != FULL_LVL);

  // Pop path: the FIFO head feeds the stream directly, with no register in between.
  assign w_pop  = w_pop_en && fifo_out_vld && m_rdy;
  assign w_last = (r_pop_cnt == (r_len - LEN_ONE));

  assign w_ovf = w_busy && (fifo_overflow || (w_push && (fifo_size == FULL_LVL)));

  assign fifo_in_vld  = w_push;
  assign fifo_in_data = w_push_en ? src_data : '0;
  assign m_vld        = w_pop_en && fifo_out_vld;
  assign m_data       = w_pop_en ? fifo_out_data : '0;
  assign m_last       = m_vld && w_last;
  assign fifo_out_rdy = w_pop;

  assign busy     = w_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign fifo_clr = r_fifo_clr;
  assign push_cnt = r_push_cnt;
  assign pop_cnt  = r_pop_cnt;

  // Registered status, burst length and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_clr <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= '0;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
    end else begin
      r_fifo_clr <= abort || (w_next == S_CLR);
      r_done     <= (w_next == S_DONE);
      if (abort)      r_err <= 1'b0;
      else if (w_ovf) r_err <= 1'b1;
      if (w_start_ok) begin
        r_len      <= w_len_clamped;
        r_push_cnt <= '0;
        r_pop_cnt  <= '0;
      end else begin
        if (w_push_acc && (r_push_cnt < r_len)) r_push_cnt <= r_push_cnt + LEN_ONE;
        if (w_pop && (r_pop_cnt < r_len))       r_pop_cnt  <= r_pop_cnt + LEN_ONE;
      end
    end
  end

endmodule
